// File: rtl/var_state_xfer_pkg.sv
// Shared definitions for the variable-state transfer block: defaults,
// FSM state encoding and the variable-index to bit-range mapping.
package var_state_xfer_pkg;

    localparam int NUM_VARS_DEF         = 8;
    localparam int WIDTH_VAR_STATES_DEF = 17;
    localparam int LEVEL_W              = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STORE     = 3'd1,
        ST_LOAD_RD   = 3'd2,
        ST_LOAD_WAIT = 3'd3,
        ST_LOAD_WR   = 3'd4,
        ST_DONE      = 3'd5
    } xfer_state_e;

    // Variable 0 lives in the MSB slice; this returns the LSB position of
    // variable idx inside a num_vars*width bus.
    function automatic int slice_lsb(input int idx, input int num_vars, input int width);
        return width * (num_vars - 1 - idx);
    endfunction

endpackage

// File: rtl/var_state_xfer_if.sv
// Memory-side bus of the variable-state transfer block.
interface var_state_xfer_if #(
    parameter int ADDR_W           = 9,
    parameter int WIDTH_VAR_STATES = 17
);
    logic [ADDR_W-1:0]           addr;
    logic                        we;
    logic [WIDTH_VAR_STATES-1:0] wdata;
    logic                        re;
    logic [WIDTH_VAR_STATES-1:0] rdata;

    modport master (output addr, output we, output wdata, output re, input rdata);
    modport slave  (input addr, input we, input wdata, input re, output rdata);
endinterface

// File: rtl/var_state_xfer_buf.sv
// Snapshot / assembly register: whole-bus load for a store snapshot,
// single-slice write for assembling loaded words, indexed slice read.
module var_state_xfer_buf
    import var_state_xfer_pkg::*;
#(
    parameter int NUM_VARS         = 8,
    parameter int WIDTH_VAR_STATES = 17,
    localparam int IDX_W           = $clog2(NUM_VARS),
    localparam int BUS_W           = NUM_VARS * WIDTH_VAR_STATES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        snap_en_i,
    input  logic [BUS_W-1:0]            snap_data_i,
    input  logic                        slice_we_i,
    input  logic [IDX_W-1:0]            slice_idx_i,
    input  logic [WIDTH_VAR_STATES-1:0] slice_data_i,
    input  logic [IDX_W-1:0]            rd_idx_i,
    output logic [WIDTH_VAR_STATES-1:0] rd_data_o,
    output logic [BUS_W-1:0]            buf_o
);

    logic [BUS_W-1:0] buf_r;

    // Buffer update: snapshot has priority over a slice write.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r <= '0;
        end else if (snap_en_i) begin
            buf_r <= snap_data_i;
        end else if (slice_we_i) begin
            buf_r[slice_lsb(int'(slice_idx_i), NUM_VARS, WIDTH_VAR_STATES) +: WIDTH_VAR_STATES] <= slice_data_i;
        end else begin
            buf_r <= buf_r;
        end
    end

    assign rd_data_o = buf_r[slice_lsb(int'(rd_idx_i), NUM_VARS, WIDTH_VAR_STATES) +: WIDTH_VAR_STATES];
    assign buf_o     = buf_r;

endmodule

// File: rtl/var_state_xfer.sv
// Moves per-bin variable states between the global state memory and the
// engine's state bank. All outputs are registered: the output registers are
// loaded from the next-state decode so they line up with the FSM state.
module var_state_xfer
    import var_state_xfer_pkg::*;
#(
    parameter int NUM_VARS         = NUM_VARS_DEF,
    parameter int WIDTH_VAR_STATES = WIDTH_VAR_STATES_DEF,
    parameter int WIDTH_BIN        = 6,
    localparam int IDX_W           = $clog2(NUM_VARS),
    localparam int ADDR_W          = WIDTH_BIN + IDX_W,
    localparam int BUS_W           = NUM_VARS * WIDTH_VAR_STATES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   store_en_i,
    input  logic                   load_en_i,
    input  logic [WIDTH_BIN-1:0]   store_bin_i,
    input  logic [WIDTH_BIN-1:0]   load_bin_i,
    input  logic [BUS_W-1:0]       engine_states_i,
    output logic [BUS_W-1:0]       engine_states_o,
    output logic [NUM_VARS-1:0]    engine_wr_o,
    var_state_xfer_if.master       mem,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VARS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam int               W        = WIDTH_VAR_STATES;

    xfer_state_e          state_r, state_nxt_s;
    logic [IDX_W-1:0]     idx_r, idx_nxt_s;
    logic                 accept_s;
    logic [WIDTH_BIN-1:0] store_bin_r, load_bin_r;
    logic [WIDTH_BIN-1:0] store_bin_sel_s, load_bin_sel_s;
    logic                 load_en_r;

    logic                 cap_we_s;
    logic [IDX_W-1:0]     cap_idx_s;
    logic [W-1:0]         buf_rd_s;
    logic [BUS_W-1:0]     buf_q_s;
    logic [BUS_W-1:0]     merged_s;

    logic                 we_nxt_s, re_nxt_s, busy_nxt_s, done_nxt_s;
    logic [ADDR_W-1:0]    addr_nxt_s;
    logic [W-1:0]         wdata_nxt_s;
    logic [NUM_VARS-1:0]  eng_wr_nxt_s;
    logic [BUS_W-1:0]     eng_states_nxt_s;

    logic                 we_r, re_r, busy_r, done_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [W-1:0]         wdata_r;
    logic [NUM_VARS-1:0]  eng_wr_r;
    logic [BUS_W-1:0]     eng_states_r;

    // Next-state and index sequencing; the index wraps to 0 on each phase exit.
    always_comb begin
        accept_s    = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                idx_nxt_s = '0;
                if (accept_s) begin
                    if (store_en_i) begin
                        state_nxt_s = ST_STORE;
                    end else if (load_en_i) begin
                        state_nxt_s = ST_LOAD_RD;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STORE: begin
                idx_nxt_s = idx_r + IDX_ONE;
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = load_en_r ? ST_LOAD_RD : ST_DONE;
                end else begin
                    state_nxt_s = ST_STORE;
                end
            end
            ST_LOAD_RD: begin
                idx_nxt_s = idx_r + IDX_ONE;
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = ST_LOAD_WAIT;
                end else begin
                    state_nxt_s = ST_LOAD_RD;
                end
            end
            ST_LOAD_WAIT: state_nxt_s = ST_LOAD_WR;
            ST_LOAD_WR:   state_nxt_s = ST_DONE;
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // FSM, index and latched command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            store_bin_r <= '0;
            load_bin_r  <= '0;
            load_en_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (accept_s) begin
                store_bin_r <= store_bin_i;
                load_bin_r  <= load_bin_i;
                load_en_r   <= load_en_i;
            end else begin
                store_bin_r <= store_bin_r;
                load_bin_r  <= load_bin_r;
                load_en_r   <= load_en_r;
            end
        end
    end

    // Read data arrives one cycle after its strobe, so capture lags the
    // read index by one; in LOAD_WAIT the wrapped index minus one is the last slot.
    always_comb begin
        cap_idx_s = idx_r - IDX_ONE;
        if ((state_r == ST_LOAD_RD) && (idx_r != '0)) begin
            cap_we_s = 1'b1;
        end else if (state_r == ST_LOAD_WAIT) begin
            cap_we_s = 1'b1;
        end else begin
            cap_we_s = 1'b0;
        end
    end

    var_state_xfer_buf #(
        .NUM_VARS         (NUM_VARS),
        .WIDTH_VAR_STATES (WIDTH_VAR_STATES)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .snap_en_i    (accept_s && store_en_i),
        .snap_data_i  (engine_states_i),
        .slice_we_i   (cap_we_s),
        .slice_idx_i  (cap_idx_s),
        .slice_data_i (mem.rdata),
        .rd_idx_i     (idx_nxt_s),
        .rd_data_o    (buf_rd_s),
        .buf_o        (buf_q_s)
    );

    // The final word is still on the read bus during LOAD_WAIT; fold it in
    // directly so the engine write can be registered on the same edge.
    assign merged_s = {buf_q_s[BUS_W-1:W], mem.rdata};

    // Output decode from the upcoming state so registered outputs match it.
    always_comb begin
        store_bin_sel_s = accept_s ? store_bin_i : store_bin_r;
        load_bin_sel_s  = accept_s ? load_bin_i : load_bin_r;
        we_nxt_s        = (state_nxt_s == ST_STORE);
        re_nxt_s        = (state_nxt_s == ST_LOAD_RD);
        busy_nxt_s      = (state_nxt_s == ST_STORE) || (state_nxt_s == ST_LOAD_RD) ||
                          (state_nxt_s == ST_LOAD_WAIT) || (state_nxt_s == ST_LOAD_WR);
        done_nxt_s      = (state_nxt_s == ST_DONE);
        if (we_nxt_s) begin
            addr_nxt_s = {store_bin_sel_s, idx_nxt_s};
            if (accept_s) begin
                wdata_nxt_s = engine_states_i[BUS_W-1 -: W];
            end else begin
                wdata_nxt_s = buf_rd_s;
            end
        end else if (re_nxt_s) begin
            addr_nxt_s  = {load_bin_sel_s, idx_nxt_s};
            wdata_nxt_s = '0;
        end else begin
            addr_nxt_s  = '0;
            wdata_nxt_s = '0;
        end
        if (state_nxt_s == ST_LOAD_WR) begin
            eng_wr_nxt_s     = '1;
            eng_states_nxt_s = merged_s;
        end else begin
            eng_wr_nxt_s     = '0;
            eng_states_nxt_s = eng_states_r;
        end
    end

    // Output registers; reset clears everything including the engine bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r         <= 1'b0;
            re_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            eng_wr_r     <= '0;
            eng_states_r <= '0;
        end else begin
            we_r         <= we_nxt_s;
            re_r         <= re_nxt_s;
            addr_r       <= addr_nxt_s;
            wdata_r      <= wdata_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            eng_wr_r     <= eng_wr_nxt_s;
            eng_states_r <= eng_states_nxt_s;
        end
    end

    assign mem.we          = we_r;
    assign mem.re          = re_r;
    assign mem.addr        = addr_r;
    assign mem.wdata       = wdata_r;
    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign engine_wr_o     = eng_wr_r;
    assign engine_states_o = eng_states_r;

endmodule

// File: tb/tb_var_state_xfer.sv
// Bench for var_state_xfer: a transaction-level model expands each accepted
// command into its expected cycle sequence and checks every cycle.
module tb_var_state_xfer;

    localparam int N  = 8;
    localparam int W  = 17;
    localparam int BW = 6;
    localparam int AW = 9;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, store_en_i, load_en_i;
    logic [BW-1:0] store_bin_i, load_bin_i;
    logic [VW-1:0] engine_states_i, engine_states_o;
    logic [N-1:0]  engine_wr_o;
    logic          busy_o, done_o;

    always #5 clk = ~clk;

    var_state_xfer_if #(.ADDR_W(AW), .WIDTH_VAR_STATES(W)) mif ();

    var_state_xfer #(.NUM_VARS(N), .WIDTH_VAR_STATES(W), .WIDTH_BIN(BW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .store_en_i      (store_en_i),
        .load_en_i       (load_en_i),
        .store_bin_i     (store_bin_i),
        .load_bin_i      (load_bin_i),
        .engine_states_i (engine_states_i),
        .engine_states_o (engine_states_o),
        .engine_wr_o     (engine_wr_o),
        .mem             (mif),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: write on strobe, read data valid the cycle after re, junk otherwise.
    logic [W-1:0] tb_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mif.we) tb_mem[mif.addr] <= mif.wdata;
        if (mif.re) mif.rdata <= tb_mem[mif.addr];
        else        mif.rdata <= W'($urandom);
    end

    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [N-1:0]  wr;
        logic          busy;
        logic          done;
        logic          set_st;
        logic [VW-1:0] st;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  model_mem [0:(1<<AW)-1];
    logic [VW-1:0] exp_states = '0;
    int            total = 0, bad = 0, we_count = 0, re_count = 0;
    bit            chk_en = 1'b0;
    bit            fix_eng = 1'b0;

    function automatic exp_t idle_e();
        exp_t e;
        e.we = 1'b0; e.re = 1'b0; e.addr = '0; e.wdata = '0; e.wr = '0;
        e.busy = 1'b0; e.done = 1'b0; e.set_st = 1'b0; e.st = '0;
        return e;
    endfunction

    function automatic logic [W-1:0] get_slice(input logic [VW-1:0] v, input int i);
        return v[W*(N-1-i) +: W];
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Expand one accepted command into its expected per-cycle behaviour.
    task automatic plan(input logic s, input logic l, input logic [BW-1:0] sb,
                        input logic [BW-1:0] lb, input logic [VW-1:0] snap);
        exp_t e;
        logic [VW-1:0] ld;
        ld = '0;
        if (s) begin
            for (int i = 0; i < N; i++) begin
                e = idle_e(); e.we = 1'b1; e.busy = 1'b1;
                e.addr = {sb, 3'(i)}; e.wdata = get_slice(snap, i);
                exp_q.push_back(e);
            end
        end
        if (l) begin
            for (int i = 0; i < N; i++) begin
                if (s && (sb == lb)) ld[W*(N-1-i) +: W] = get_slice(snap, i);
                else                 ld[W*(N-1-i) +: W] = model_mem[{lb, 3'(i)}];
                e = idle_e(); e.re = 1'b1; e.busy = 1'b1; e.addr = {lb, 3'(i)};
                exp_q.push_back(e);
            end
            e = idle_e(); e.busy = 1'b1;
            exp_q.push_back(e);
            e = idle_e(); e.busy = 1'b1; e.wr = '1; e.set_st = 1'b1; e.st = ld;
            exp_q.push_back(e);
        end
        e = idle_e(); e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        exp_t cur;
        if (chk_en) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = idle_e();
            if (cur.set_st) exp_states = cur.st;
            chk("mem_bus", VW'({mif.we, mif.re, mif.addr, mif.wdata}),
                VW'({cur.we, cur.re, cur.addr, cur.wdata}));
            chk("busy_done", VW'({busy_o, done_o}), VW'({cur.busy, cur.done}));
            chk("engine_wr", VW'(engine_wr_o), VW'(cur.wr));
            chk("engine_states", engine_states_o, exp_states);
            if (cur.we) model_mem[cur.addr] = cur.wdata;
            if (mif.we) we_count++;
            if (mif.re) re_count++;
            if (rst) begin
                exp_q.delete();
                exp_states = '0;
            end else if (start_i && !cur.busy) begin
                plan(store_en_i, load_en_i, store_bin_i, load_bin_i, engine_states_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!fix_eng) begin
            for (int i = 0; i < N; i++) engine_states_i[W*i +: W] = W'($urandom);
        end
    endtask

    task automatic drive(input logic s, input logic l, input logic [BW-1:0] sb, input logic [BW-1:0] lb);
        start_i = 1'b1; store_en_i = s; load_en_i = l; store_bin_i = sb; load_bin_i = lb;
    endtask

    task automatic wait_done(input int c0, output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    task automatic run_cmd(input logic s, input logic l, input logic [BW-1:0] sb,
                           input logic [BW-1:0] lb, output int lat);
        int c0;
        tick();
        drive(s, l, sb, lb);
        c0 = cyc;
        tick();
        start_i = 1'b0;
        wait_done(c0, lat);
    endtask

    initial begin
        int lat, c0, c1, dcnt;
        logic [VW-1:0] snap;
        logic [W-1:0] v;
        rst = 1'b1; start_i = 1'b0; store_en_i = 1'b0; load_en_i = 1'b0;
        store_bin_i = '0; load_bin_i = '0; engine_states_i = '0;
        for (int a = 0; a < (1 << AW); a++) begin
            v = W'($urandom);
            tb_mem[a] = v;
            model_mem[a] = v;
        end
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", VW'({busy_o, done_o, mif.we, mif.re, engine_wr_o}), VW'(0));

        // Store-only, bin 3, slice i = 0x100+i.
        fix_eng = 1'b1;
        for (int i = 0; i < N; i++) engine_states_i[W*(N-1-i) +: W] = W'(17'h100 + i);
        we_count = 0;
        run_cmd(1'b1, 1'b0, 6'd3, 6'd0, lat);
        chk("store_latency", VW'(lat), VW'(9));
        chk("store_we_count", VW'(we_count), VW'(8));
        for (int i = 0; i < N; i++) chk("store_mem_word", VW'(tb_mem[24 + i]), VW'(17'h100 + i));

        // Load-only, bin 5, preloaded 0x1A0+i.
        for (int i = 0; i < N; i++) begin
            tb_mem[40 + i] = W'(17'h1A0 + i);
            model_mem[40 + i] = W'(17'h1A0 + i);
        end
        run_cmd(1'b0, 1'b1, 6'd0, 6'd5, lat);
        chk("load_latency", VW'(lat), VW'(11));
        for (int i = 0; i < N; i++)
            chk("load_slice", VW'(engine_states_o[W*(N-1-i) +: W]), VW'(17'h1A0 + i));

        // Swap on the same bin returns the snapshot.
        for (int i = 0; i < N; i++) engine_states_i[W*i +: W] = W'($urandom);
        snap = engine_states_i;
        run_cmd(1'b1, 1'b1, 6'd2, 6'd2, lat);
        chk("swap_latency", VW'(lat), VW'(19));
        chk("swap_states", engine_states_o, snap);

        // Starts during a store are ignored; a start in the done cycle is taken.
        we_count = 0;
        tick();
        drive(1'b1, 1'b0, 6'd1, 6'd0);
        c0 = cyc;
        while (cyc < c0 + 9) begin
            tick();
            if ((cyc == c0 + 4) || (cyc == c0 + 7)) drive(1'b1, 1'b1, 6'd7, 6'd9);
            else start_i = 1'b0;
        end
        drive(1'b1, 1'b0, 6'd4, 6'd0);
        c1 = cyc;
        @(negedge clk);
        chk("done_cycle_9", VW'(done_o), VW'(1'b1));
        tick();
        start_i = 1'b0;
        wait_done(c1, lat);
        chk("back_to_back_latency", VW'(lat), VW'(9));
        chk("ignored_start_writes", VW'(we_count), VW'(16));

        // Reset in the middle of a swap.
        tick();
        drive(1'b1, 1'b1, 6'd6, 6'd6);
        c0 = cyc;
        tick();
        start_i = 1'b0;
        while (cyc < c0 + 12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy_strobes", VW'({busy_o, mif.we, mif.re, engine_wr_o}), VW'(0));
        chk("abort_states", engine_states_o, VW'(0));
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_o) dcnt++;
        end
        chk("abort_no_done", VW'(dcnt), VW'(0));

        // Both enables clear: immediate done, no memory traffic.
        we_count = 0; re_count = 0;
        run_cmd(1'b0, 1'b0, 6'd1, 6'd1, lat);
        chk("empty_latency", VW'(lat), VW'(1));
        chk("empty_no_traffic", VW'(we_count + re_count), VW'(0));

        // Randomized traffic with occasional resets.
        fix_eng = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tick();
            rst = ($urandom_range(99) < 2) ? 1'b1 : 1'b0;
            start_i = ($urandom_range(3) == 0) ? 1'b1 : 1'b0;
            store_en_i = 1'(($urandom_range(1)));
            load_en_i = 1'(($urandom_range(1)));
            store_bin_i = BW'($urandom_range(3));
            load_bin_i = BW'($urandom_range(3));
        end
        tick();
        rst = 1'b0; start_i = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        @(negedge clk);
        chk("final_idle", VW'({busy_o, mif.we, mif.re}), VW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
